clock_reconfig_sequencer: RTL
=============================

# clock_reconfig_sequencer

Sequences a full clock-tree reconfiguration for the ADC/target clock manager. It resets the frequency-synthesis DCM, loads new M/D values, and waits for generator lock. It then resets the ADC DCM, waits for ADC lock, and finally reapplies the requested phase shift. It sits beside the clock manager in the phase-clock domain, replacing ad-hoc host register sequencing with one start/done handshake plus timeout, retry and error reporting.

## Interface
Parameters:
- RST_CYCLES, 8: cycles each DCM reset is held high (2..255).
- LOCK_HOLD, 16: consecutive synchronized-lock-high cycles required to declare lock.
- TMR_W, 20: timeout counter width; timeout = 2^TMR_W-1 cycles per wait state.
- MAX_RETRY, 3: full-sequence retries after a timeout before ERROR (0..7).

Ports:
- clk_i  in  1  phase/program clock, same domain as the M/D loader and phase-shift interface.
- reset_n_i  in  1  **one clock; reset is asynchronous and active-low.**
- start_i  in  1  single-cycle request; accepted only when busy_o=0.
- mul_i / div_i  in  8  new M/D values, captured on an accepted start.
- phase_i  in  9  phase value, captured on an accepted start.
- busy_o  out  1  high from the cycle after an accepted start until DONE or ERROR.
- done_o  out  1  one-cycle pulse on success.
- error_o  out  1  sticky; cleared by the next accepted start.
- err_code_o  out  3  0 none, 1 clkgen-done timeout, 2 gen-lock timeout, 3 adc-lock timeout, 4 phase-done timeout, 5 lock lost (monitor).
- retry_cnt_o  out  3  retries consumed in the current or last run.
- clkgen_reset_o, clkgen_load_o  out  1  to the M/D loader.
- clkgen_mul_o, clkgen_div_o  out  8  registered captured M/D.
- clkgen_done_i  in  1  loader done level.
- dcm_gen_locked_i, dcm_adc_locked_i  in  1  asynchronous; 2-flop synchronized internally.
- dcm_reset_o  out  1  ADC DCM reset.
- phase_load_o  out  1  to the phase-shift interface.
- phase_requested_o  out  9  registered captured phase.
- phase_done_i  in  1  phase-shift done level.

## Operation
- Reset values: all outputs 0, state IDLE, retry 0, err_code 0.
- States and transitions:
  - IDLE → GEN_RST on start.
  - GEN_RST (clkgen_reset_o=1, dcm_reset_o=1, RST_CYCLES) → GEN_LOAD.
  - GEN_LOAD (clkgen_load_o=1 for 1 cycle) → GEN_WAIT_DONE.
  - GEN_WAIT_DONE: wait for clkgen_done_i=1, sampled only from the 3rd cycle after the load pulse → GEN_WAIT_LOCK.
  - GEN_WAIT_LOCK → ADC_RST once gen lock has held LOCK_HOLD cycles.
  - ADC_RST (dcm_reset_o=1, RST_CYCLES) → ADC_WAIT_LOCK.
  - ADC_WAIT_LOCK → PH_LOAD once ADC lock has held LOCK_HOLD cycles.
  - PH_LOAD (phase_load_o=1 for 1 cycle) → PH_WAIT.
  - PH_WAIT: wait for phase_done_i=1, sampled from the 3rd cycle after the load pulse → DONE.
  - DONE: done_o pulses for 1 cycle → IDLE, or MONITOR when the monitor is configured in.
- Lock hold counter: reset to 0 on any synchronized low sample; saturates at LOCK_HOLD.
- Timeout: the timer clears on every state entry and counts in every WAIT state.
  - On expiry with retry_cnt<MAX_RETRY: increment retry_cnt, go to GEN_RST.
  - Otherwise: go to ERROR, set error_o and err_code_o.
- ERROR → IDLE on the next cycle. Outputs other than error_o, err_code_o and retry_cnt_o are 0 in ERROR.
- start while busy_o=1: ignored, with no side effects.
- Accepted start: clears error_o, err_code_o and retry_cnt_o, and captures the inputs.
- Reset mid-sequence: all outputs drop asynchronously, including clkgen_reset_o and dcm_reset_o. The DCMs are not left in reset.

## Timing
- Accepted start → clkgen_reset_o high on the next edge; busy_o high on the same edge.
- Reset pulses are exactly RST_CYCLES cycles; load pulses are exactly 1 cycle.
- Lock input → synchronized sample latency is 2 cycles. Minimum GEN_WAIT_LOCK dwell is LOCK_HOLD+2 cycles.
- Minimum successful run is 2·RST_CYCLES + 2·(LOCK_HOLD+2) + 8 cycles.
- done_o asserts in the cycle busy_o falls.

## Configuration
- CLKSEQ_LOCK_MONITOR_EN defined:
  - After DONE, enter MONITOR with busy_o=0 and continuously watch both synchronized locks.
  - Any low sample for 2 consecutive cycles sets error_o with err_code 5 and returns to IDLE.
  - start in MONITOR is accepted normally.
- Undefined: DONE → IDLE, lock inputs are ignored outside the wait states, and err_code 5 is never produced.

## Structure
- Shared include/package clock_seq_pkg:
  - state encoding localparams;
  - err_code constants (ERR_NONE…ERR_LOCKLOST);
  - default parameter values.
- One sub-module, clkseq_lock_filter: 2-flop synchronizer plus hold counter, outputs lock_stable. It is instantiated twice, once for gen lock and once for ADC lock.
- The timeout counter stays inline.

## Test plan
- Nominal: start with mul=8, div=4, phase=0x010; models return done 5 cycles after load and lock 30 cycles after reset release → done_o pulse once, clkgen_mul_o=8, clkgen_div_o=4, phase_requested_o=0x010, retry_cnt_o=0.
- Gen lock never asserts, MAX_RETRY=3, TMR_W=8 → exactly 4 GEN_RST pulses, then error_o=1, err_code_o=2, retry_cnt_o=3, no done_o.
- Lock glitch: gen lock drops for 1 cycle at hold count 10 → hold restarts; lock is declared only after 16 further clean cycles.
- start pulsed during GEN_WAIT_DONE with different mul → ignored; the original mul is retained and a single done_o is produced.
- reset_n_i low during ADC_RST → dcm_reset_o and busy_o fall without waiting for a clock edge; after release, state is IDLE with all outputs 0.
- With CLKSEQ_LOCK_MONITOR_EN: after done, ADC lock low for 2 cycles → error_o=1, err_code_o=5. A 1-cycle drop produces no error.

Source files
------------

// File: rtl/clock_seq_pkg.sv
// Shared constants for the clock-tree reconfiguration sequencer:
// FSM state encoding, error codes and default parameter values.
package clock_seq_pkg;

  localparam logic [3:0] ST_IDLE          = 4'd0;
  localparam logic [3:0] ST_GEN_RST       = 4'd1;
  localparam logic [3:0] ST_GEN_LOAD      = 4'd2;
  localparam logic [3:0] ST_GEN_WAIT_DONE = 4'd3;
  localparam logic [3:0] ST_GEN_WAIT_LOCK = 4'd4;
  localparam logic [3:0] ST_ADC_RST       = 4'd5;
  localparam logic [3:0] ST_ADC_WAIT_LOCK = 4'd6;
  localparam logic [3:0] ST_PH_LOAD       = 4'd7;
  localparam logic [3:0] ST_PH_WAIT       = 4'd8;
  localparam logic [3:0] ST_DONE          = 4'd9;
  localparam logic [3:0] ST_ERROR         = 4'd10;
  localparam logic [3:0] ST_MONITOR       = 4'd11;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_CLKGEN   = 3'd1;
  localparam logic [2:0] ERR_GENLOCK  = 3'd2;
  localparam logic [2:0] ERR_ADCLOCK  = 3'd3;
  localparam logic [2:0] ERR_PHASE    = 3'd4;
  localparam logic [2:0] ERR_LOCKLOST = 3'd5;

  localparam int DEF_RST_CYCLES = 8;
  localparam int DEF_LOCK_HOLD  = 16;
  localparam int DEF_TMR_W      = 20;
  localparam int DEF_MAX_RETRY  = 3;

endpackage

// File: rtl/clkseq_lock_filter.sv
// 2-flop lock synchronizer plus saturating hold counter.
// Ports: i_clk, i_rst_n, i_clr (restart hold), i_lock (async), o_sync, o_stable.
module clkseq_lock_filter
  import clock_seq_pkg::*;
#(
  parameter int LOCK_HOLD = DEF_LOCK_HOLD
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_lock,
  output logic o_sync,
  output logic o_stable
);

  localparam int CW = $clog2(LOCK_HOLD + 1);
  localparam logic [CW-1:0] HOLD = CW'(LOCK_HOLD);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
      r_cnt  <= '0;
    end else begin
      r_sync <= {r_sync[0], i_lock};
      // any low sample restarts the hold window
      if (i_clr || !r_sync[1])
        r_cnt <= '0;
      else if (r_cnt != HOLD)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_sync   = r_sync[1];
  assign o_stable = (r_cnt == HOLD);

endmodule

// File: rtl/clock_reconfig_sequencer.sv
// Sequences DCM reset, M/D load, lock waits and phase reapply with timeout/retry.
// Ports: start/M/D/phase request, busy/done/error status, loader, DCM and phase controls.
// Option: CLKSEQ_LOCK_MONITOR_EN adds a post-done lock-loss monitor (err_code 5).
module clock_reconfig_sequencer
  import clock_seq_pkg::*;
#(
  parameter int RST_CYCLES = DEF_RST_CYCLES,
  parameter int LOCK_HOLD  = DEF_LOCK_HOLD,
  parameter int TMR_W      = DEF_TMR_W,
  parameter int MAX_RETRY  = DEF_MAX_RETRY
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       start_i,
  input  logic [7:0] mul_i,
  input  logic [7:0] div_i,
  input  logic [8:0] phase_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       error_o,
  output logic [2:0] err_code_o,
  output logic [2:0] retry_cnt_o,
  output logic       clkgen_reset_o,
  output logic       clkgen_load_o,
  output logic [7:0] clkgen_mul_o,
  output logic [7:0] clkgen_div_o,
  input  logic       clkgen_done_i,
  input  logic       dcm_gen_locked_i,
  input  logic       dcm_adc_locked_i,
  output logic       dcm_reset_o,
  output logic       phase_load_o,
  output logic [8:0] phase_requested_o,
  input  logic       phase_done_i
);

  localparam logic [TMR_W-1:0] RST_LAST  = TMR_W'(RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] SMP_FIRST = TMR_W'(2);
  localparam logic [2:0]       RETRY_MAX = 3'(MAX_RETRY);

  logic [3:0]       r_state;
  logic [3:0]       w_next;
  logic [TMR_W-1:0] r_tmr;
  logic [2:0]       r_retry;
  logic [2:0]       r_err_code;
  logic             r_error;
  logic [7:0]       r_mul;
  logic [7:0]       r_div;
  logic [8:0]       r_phase;

  logic       w_busy, w_accept, w_wait, w_tmr_en;
  logic       w_expired, w_sample, w_retry, w_fail, w_lost;
  logic       w_gen_sync, w_gen_stable, w_adc_sync, w_adc_stable;
  logic       w_err_st;
  logic [2:0] w_code;

  assign w_busy   = !(r_state inside {ST_IDLE, ST_DONE, ST_ERROR, ST_MONITOR});
  assign w_accept = start_i && !w_busy;
  assign w_wait   = r_state inside {ST_GEN_WAIT_DONE, ST_GEN_WAIT_LOCK,
                                    ST_ADC_WAIT_LOCK, ST_PH_WAIT};
  assign w_tmr_en  = w_wait || (r_state inside {ST_GEN_RST, ST_ADC_RST});
  assign w_expired = w_wait && (&r_tmr);
  // done levels are ignored for two cycles after the load pulse
  assign w_sample  = (r_tmr >= SMP_FIRST);

  clkseq_lock_filter #(.LOCK_HOLD(LOCK_HOLD)) u_gen_lock (
    .i_clk    (clk_i),
    .i_rst_n  (reset_n_i),
    .i_clr    (clkgen_reset_o),
    .i_lock   (dcm_gen_locked_i),
    .o_sync   (w_gen_sync),
    .o_stable (w_gen_stable)
  );

  clkseq_lock_filter #(.LOCK_HOLD(LOCK_HOLD)) u_adc_lock (
    .i_clk    (clk_i),
    .i_rst_n  (reset_n_i),
    .i_clr    (dcm_reset_o),
    .i_lock   (dcm_adc_locked_i),
    .o_sync   (w_adc_sync),
    .o_stable (w_adc_stable)
  );

`ifdef CLKSEQ_LOCK_MONITOR_EN
  localparam logic [3:0] DONE_NEXT = ST_MONITOR;
  logic r_gen_low, r_adc_low;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_gen_low <= 1'b0;
      r_adc_low <= 1'b0;
    end else begin
      r_gen_low <= (r_state == ST_MONITOR) && !w_gen_sync;
      r_adc_low <= (r_state == ST_MONITOR) && !w_adc_sync;
    end
  end

  // two consecutive low samples on either lock
  assign w_lost = (r_state == ST_MONITOR) &&
                  ((r_gen_low && !w_gen_sync) || (r_adc_low && !w_adc_sync));
`else
  localparam logic [3:0] DONE_NEXT = ST_IDLE;
  logic w_unused_sync;
  assign w_unused_sync = w_gen_sync ^ w_adc_sync;
  assign w_lost = 1'b0;
`endif

  always_comb begin
    w_next  = r_state;
    w_code  = ERR_NONE;
    w_retry = 1'b0;
    w_fail  = 1'b0;
    unique case (r_state)
      ST_IDLE:     if (start_i) w_next = ST_GEN_RST;
      ST_GEN_RST:  if (r_tmr == RST_LAST) w_next = ST_GEN_LOAD;
      ST_GEN_LOAD: w_next = ST_GEN_WAIT_DONE;
      ST_GEN_WAIT_DONE: begin
        w_code = ERR_CLKGEN;
        if (w_sample && clkgen_done_i) w_next = ST_GEN_WAIT_LOCK;
      end
      ST_GEN_WAIT_LOCK: begin
        w_code = ERR_GENLOCK;
        if (w_gen_stable) w_next = ST_ADC_RST;
      end
      ST_ADC_RST:  if (r_tmr == RST_LAST) w_next = ST_ADC_WAIT_LOCK;
      ST_ADC_WAIT_LOCK: begin
        w_code = ERR_ADCLOCK;
        if (w_adc_stable) w_next = ST_PH_LOAD;
      end
      ST_PH_LOAD:  w_next = ST_PH_WAIT;
      ST_PH_WAIT: begin
        w_code = ERR_PHASE;
        if (w_sample && phase_done_i) w_next = ST_DONE;
      end
      ST_DONE:  w_next = start_i ? ST_GEN_RST : DONE_NEXT;
      ST_ERROR: w_next = start_i ? ST_GEN_RST : ST_IDLE;
      ST_MONITOR: begin
        if (start_i) begin
          w_next = ST_GEN_RST;
        end else if (w_lost) begin
          w_next = ST_IDLE;
          w_code = ERR_LOCKLOST;
          w_fail = 1'b1;
        end
      end
      default: w_next = ST_IDLE;
    endcase
    // a wait that completes on its last cycle still counts as success
    if (w_expired && (w_next == r_state)) begin
      if (r_retry < RETRY_MAX) begin
        w_retry = 1'b1;
        w_next  = ST_GEN_RST;
      end else begin
        w_fail = 1'b1;
        w_next = ST_ERROR;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state    <= ST_IDLE;
      r_tmr      <= '0;
      r_retry    <= '0;
      r_err_code <= ERR_NONE;
      r_error    <= 1'b0;
      r_mul      <= '0;
      r_div      <= '0;
      r_phase    <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_tmr <= '0;
      else if (w_tmr_en)
        r_tmr <= r_tmr + 1'b1;
      if (w_accept) begin
        r_error    <= 1'b0;
        r_err_code <= ERR_NONE;
        r_retry    <= '0;
        r_mul      <= mul_i;
        r_div      <= div_i;
        r_phase    <= phase_i;
      end else if (w_retry) begin
        r_retry <= r_retry + 1'b1;
      end else if (w_fail) begin
        r_error    <= 1'b1;
        r_err_code <= w_code;
      end
    end
  end

  assign w_err_st = (r_state == ST_ERROR);

  assign busy_o            = w_busy;
  assign done_o            = (r_state == ST_DONE);
  assign error_o           = r_error;
  assign err_code_o        = r_err_code;
  assign retry_cnt_o       = r_retry;
  assign clkgen_reset_o    = (r_state == ST_GEN_RST);
  assign clkgen_load_o     = (r_state == ST_GEN_LOAD);
  assign dcm_reset_o       = (r_state == ST_GEN_RST) || (r_state == ST_ADC_RST);
  assign phase_load_o      = (r_state == ST_PH_LOAD);
  assign clkgen_mul_o      = w_err_st ? 8'd0 : r_mul;
  assign clkgen_div_o      = w_err_st ? 8'd0 : r_div;
  assign phase_requested_o = w_err_st ? 9'd0 : r_phase;

endmodule
